// File: rtl/core_pkg.sv
// core_pkg: shared widths, register indices and result record for the core
package core_pkg;
  localparam int N = 32;
  localparam int NUM_REGS = 16;
  localparam logic [3:0] REG_PC = 4'd15;
  typedef struct packed {
    logic valid;
    logic [3:0] rd;
    logic [N-1:0] data;
  } result_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register in-flight write counters for RAW hazard detection
module wb_scoreboard
  import core_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iss_valid,
  input  logic [3:0] iss_rd,
  output logic       iss_ready,
  input  logic       ret0_valid,
  input  logic [3:0] ret0_rd,
  input  logic       ret1_valid,
  input  logic [3:0] ret1_rd,
  input  logic [3:0] chk_addr1,
  input  logic [3:0] chk_addr2,
  input  logic [3:0] chk_addr3,
  output logic       chk_busy1,
  output logic       chk_busy2,
  output logic       chk_busy3,
  output logic       sb_err
);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] inc, dec, err;
  assign iss_ready = cnt[iss_rd] != MAX;
  assign chk_busy1 = cnt[chk_addr1] != '0;
  assign chk_busy2 = cnt[chk_addr2] != '0;
  assign chk_busy3 = cnt[chk_addr3] != '0;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
    assign inc[i] = iss_valid && iss_ready && iss_rd == 4'(i);
    assign dec[i] = (ret0_valid && ret0_rd == 4'(i)) || (ret1_valid && ret1_rd == 4'(i));
    // a retire against an empty counter is flagged and saturates at zero
    assign err[i] = dec[i] && cnt[i] == '0;
    assign cnt_nxt[i] = (inc[i] && !dec[i]) ? cnt[i] + 1'b1 :
                        (dec[i] && !inc[i] && cnt[i] != '0) ? cnt[i] - 1'b1 : cnt[i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      sb_err <= sb_err || (|err);
    end
  end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: routes ALU/load results onto register bank ports one cycle later
module writeback_unit
  import core_pkg::*;
#(
  parameter int N = core_pkg::N,
  parameter int CNT_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iss_valid,
  input  logic [3:0]   iss_rd,
  output logic         iss_ready,
  input  logic [3:0]   chk_addr1,
  input  logic [3:0]   chk_addr2,
  input  logic [3:0]   chk_addr3,
  output logic         chk_busy1,
  output logic         chk_busy2,
  output logic         chk_busy3,
  input  logic         res0_valid,
  input  logic [3:0]   res0_rd,
  input  logic [N-1:0] res0_data,
  input  logic         res0_flags_we,
  input  logic [N-1:0] res0_flags,
  input  logic         res1_valid,
  output logic         res1_ready,
  input  logic [3:0]   res1_rd,
  input  logic [N-1:0] res1_data,
  output logic [3:0]   write_address,
  output logic [N-1:0] write_data,
  output logic         write_enable,
  output logic [3:0]   write_address2,
  output logic [N-1:0] write_data2,
  output logic         write_enable2,
  output logic [N-1:0] pc_update,
  output logic         pc_write,
  output logic [N-1:0] cspr_update,
  output logic         cspr_write,
  output logic         sb_err
);
  logic acc1, w0, w1, p0, p1, cw;
  // same destination from both sources (PC or WAW): ALU wins, load is held
  assign res1_ready = !(res0_valid && res1_valid && res0_rd == res1_rd);
  assign acc1 = res1_valid && res1_ready;
  assign w0 = res0_valid && res0_rd != REG_PC;
  assign p0 = res0_valid && res0_rd == REG_PC;
  assign w1 = acc1 && res1_rd != REG_PC;
  assign p1 = acc1 && res1_rd == REG_PC;
  assign cw = res0_valid && res0_flags_we;
  wb_scoreboard #(.CNT_W(CNT_W)) u_sb (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .ret0_valid(res0_valid), .ret0_rd(res0_rd),
    .ret1_valid(acc1), .ret1_rd(res1_rd),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_addr3(chk_addr3),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2), .chk_busy3(chk_busy3),
    .sb_err(sb_err)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_address <= '0;
      write_data <= '0;
      write_enable <= 1'b0;
      write_address2 <= '0;
      write_data2 <= '0;
      write_enable2 <= 1'b0;
      pc_update <= '0;
      pc_write <= 1'b0;
      cspr_update <= '0;
      cspr_write <= 1'b0;
    end else begin
      write_enable <= w0;
      write_enable2 <= w1;
      pc_write <= p0 || p1;
      cspr_write <= cw;
      if (w0) begin
        write_address <= res0_rd;
        write_data <= res0_data;
      end
      if (w1) begin
        write_address2 <= res1_rd;
        write_data2 <= res1_data;
      end
      if (p0 || p1) pc_update <= p0 ? res0_data : res1_data;
      if (cw) cspr_update <= res0_flags;
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: table-driven vectors with a queue scoreboard for writeback_unit
module tb_writeback_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic iss_valid = 0, res0_valid = 0, res0_flags_we = 0, res1_valid = 0;
  logic [3:0] iss_rd = 0, chk_addr1 = 0, chk_addr2 = 0, chk_addr3 = 0, res0_rd = 0, res1_rd = 0;
  logic [31:0] res0_data = 0, res0_flags = 0, res1_data = 0;
  logic iss_ready, chk_busy1, chk_busy2, chk_busy3, res1_ready;
  logic [3:0] write_address, write_address2;
  logic [31:0] write_data, write_data2, pc_update, cspr_update;
  logic write_enable, write_enable2, pc_write, cspr_write, sb_err;
  always #5 clk = ~clk;
  writeback_unit dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_addr3(chk_addr3),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2), .chk_busy3(chk_busy3),
    .res0_valid(res0_valid), .res0_rd(res0_rd), .res0_data(res0_data),
    .res0_flags_we(res0_flags_we), .res0_flags(res0_flags),
    .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_rd(res1_rd), .res1_data(res1_data),
    .write_address(write_address), .write_data(write_data), .write_enable(write_enable),
    .write_address2(write_address2), .write_data2(write_data2), .write_enable2(write_enable2),
    .pc_update(pc_update), .pc_write(pc_write), .cspr_update(cspr_update), .cspr_write(cspr_write),
    .sb_err(sb_err)
  );
  typedef struct packed {
    logic iv; logic [3:0] ir;
    logic r0v; logic [3:0] r0rd; logic [31:0] r0d; logic fwe; logic [31:0] fl;
    logic r1v; logic [3:0] r1rd; logic [31:0] r1d;
    logic e_ird; logic e_rdy;
  } vec_t;
  typedef struct packed {
    logic we; logic [3:0] wa; logic [31:0] wd;
    logic we2; logic [3:0] wa2; logic [31:0] wd2;
    logic pcw; logic [31:0] pcu; logic csw; logic [31:0] csu; logic err;
  } exp_t;
  exp_t q[$];
  exp_t h;
  logic [1:0] m_cnt [16];
  int errors = 0, checks = 0;
  vec_t tbl[$];
  vec_t v;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_busy_all(input string tag);
    chk({tag, " busy1"}, 32'(chk_busy1), 32'(m_cnt[chk_addr1] != 0));
    chk({tag, " busy2"}, 32'(chk_busy2), 32'(m_cnt[chk_addr2] != 0));
    chk({tag, " busy3"}, 32'(chk_busy3), 32'(m_cnt[chk_addr3] != 0));
  endtask
  task automatic model_reset();
    h = '0;
    q.delete();
    for (int r = 0; r < 16; r++) m_cnt[r] = 0;
  endtask
  task automatic cycle(input vec_t t);
    exp_t e;
    logic acc1, inc, dec;
    iss_valid = t.iv; iss_rd = t.ir;
    res0_valid = t.r0v; res0_rd = t.r0rd; res0_data = t.r0d; res0_flags_we = t.fwe; res0_flags = t.fl;
    res1_valid = t.r1v; res1_rd = t.r1rd; res1_data = t.r1d;
    chk_addr1 = t.r0rd; chk_addr2 = t.r1rd; chk_addr3 = t.ir;
    #1;
    chk("iss_ready", 32'(iss_ready), 32'(t.e_ird));
    chk("res1_ready", 32'(res1_ready), 32'(t.e_rdy));
    chk_busy_all("pre");
    e = h;
    e.we = t.r0v && t.r0rd != 15;
    if (e.we) begin e.wa = t.r0rd; e.wd = t.r0d; end
    acc1 = t.r1v && t.e_rdy;
    e.we2 = acc1 && t.r1rd != 15;
    if (e.we2) begin e.wa2 = t.r1rd; e.wd2 = t.r1d; end
    e.pcw = (t.r0v && t.r0rd == 15) || (acc1 && t.r1rd == 15);
    if (t.r0v && t.r0rd == 15) e.pcu = t.r0d;
    else if (acc1 && t.r1rd == 15) e.pcu = t.r1d;
    e.csw = t.r0v && t.fwe;
    if (e.csw) e.csu = t.fl;
    for (int r = 0; r < 16; r++) begin
      inc = t.iv && t.e_ird && t.ir == 4'(r);
      dec = (t.r0v && t.r0rd == 4'(r)) || (acc1 && t.r1rd == 4'(r));
      if (dec && m_cnt[r] == 0) e.err = 1'b1;
      if (inc && !dec) m_cnt[r] = m_cnt[r] + 2'd1;
      else if (dec && !inc && m_cnt[r] != 0) m_cnt[r] = m_cnt[r] - 2'd1;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("write_enable", 32'(write_enable), 32'(e.we));
    chk("write_address", 32'(write_address), 32'(e.wa));
    chk("write_data", write_data, e.wd);
    chk("write_enable2", 32'(write_enable2), 32'(e.we2));
    chk("write_address2", 32'(write_address2), 32'(e.wa2));
    chk("write_data2", write_data2, e.wd2);
    chk("pc_write", 32'(pc_write), 32'(e.pcw));
    chk("pc_update", pc_update, e.pcu);
    chk("cspr_write", 32'(cspr_write), 32'(e.csw));
    chk("cspr_update", cspr_update, e.csu);
    chk("sb_err", 32'(sb_err), 32'(e.err));
    chk_busy_all("post");
    h = e;
  endtask
  task automatic chk_zero_outputs(input string tag);
    chk({tag, " write_enable"}, 32'(write_enable), 0);
    chk({tag, " write_address"}, 32'(write_address), 0);
    chk({tag, " write_data"}, write_data, 0);
    chk({tag, " write_enable2"}, 32'(write_enable2), 0);
    chk({tag, " write_data2"}, write_data2, 0);
    chk({tag, " pc_write"}, 32'(pc_write), 0);
    chk({tag, " pc_update"}, pc_update, 0);
    chk({tag, " cspr_write"}, 32'(cspr_write), 0);
    chk({tag, " cspr_update"}, cspr_update, 0);
    chk({tag, " sb_err"}, 32'(sb_err), 0);
  endtask
  initial begin
    model_reset();
    #12;
    chk_zero_outputs("reset");
    chk_addr1 = 4'd3; chk_addr2 = 4'd5; chk_addr3 = 4'd15;
    #1;
    chk_busy_all("reset");
    @(negedge clk);
    rst = 1'b0;
    // issue r5, retire it from the ALU, then idle
    v = '{1'b1, 4'd5, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1}; cycle(v);
    v = '{1'b0, 4'd5, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1}; cycle(v);
    v = '{1'b0, 4'd5, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1}; cycle(v);
    tbl.push_back('{1'b1, 4'd1, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4'd9, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4'd15, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4'd15, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'd0, 1'b1, 4'd1, 32'h11111111, 1'b1, 32'h60000000, 1'b1, 4'd9, 32'h99999999, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'd0, 1'b1, 4'd15, 32'h00001000, 1'b0, 32'h0, 1'b1, 4'd15, 32'h00002000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd15, 32'h00002000, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'd2, 1'b1, 4'd2, 32'h00000022, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 4'd2, 1'b1, 4'd2, 32'h00000023, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'd0, 1'b1, 4'd7, 32'h00000077, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'd7, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'd7, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1});
    for (int i = 0; i < tbl.size(); i++) cycle(tbl[i]);
    // reset mid-burst with r3 pending twice and a write pulse on port 1
    v = '{1'b1, 4'd3, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1}; cycle(v);
    v = '{1'b1, 4'd3, 1'b1, 4'd4, 32'h0000ABCD, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1}; cycle(v);
    iss_valid = 1'b0;
    res0_valid = 1'b1; res0_rd = 4'd3; res0_data = 32'h33333333;
    chk_addr1 = 4'd3;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_zero_outputs("midreset");
    chk("midreset busy r3", 32'(chk_busy1), 0);
    @(negedge clk);
    res0_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset write_enable", 32'(write_enable), 0);
    chk("post-reset busy r3", 32'(chk_busy1), 0);
    chk("post-reset sb_err", 32'(sb_err), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
